// File: rtl/looper_mix_pkg.sv
// Shared types and helpers for the loop-bank mixer: FSM states, saturation
// result struct, gain/width helpers. Supports accumulators up to 64 bits.
package looper_mix_pkg;

  localparam int ACC_MAX_W = 64;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, COMMIT} mix_state_e;

  typedef struct packed {
    logic                        clip;
    logic signed [ACC_MAX_W-1:0] value;
  } sat_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Gain word meaning 1.0 for a Q1.(gain_w-1) gain.
  function automatic int gain_unity(input int gain_w);
    return 1 << (gain_w - 1);
  endfunction

  // Drop the gain fraction bits, then clamp to a signed sample_w range.
  function automatic sat_t sat_shift(input logic signed [ACC_MAX_W-1:0] acc,
                                     input int shift, input int sample_w);
    logic signed [ACC_MAX_W-1:0] shifted;
    logic signed [ACC_MAX_W-1:0] hi;
    logic signed [ACC_MAX_W-1:0] lo;
    sat_t r;
    shifted = acc >>> shift;
    hi = '0;
    hi[sample_w-1] = 1'b1;
    hi = hi - ACC_MAX_W'(1);
    lo = ~hi;
    r.clip  = 1'b0;
    r.value = shifted;
    if (shifted > hi) begin
      r.clip  = 1'b1;
      r.value = hi;
    end else if (shifted < lo) begin
      r.clip  = 1'b1;
      r.value = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/loop_mix_mac.sv
// One signed multiply-accumulate lane: stage 1 multiplies (word and/or seed),
// stage 2 adds into the accumulator. A clear replaces the sum with the seed.
module loop_mix_mac
  import looper_mix_pkg::*;
#(
  parameter int SAMPLE_W = 24,
  parameter int GAIN_W   = 8,
  parameter int ACC_W    = 37
) (
  input  logic                       clk_100MHz,
  input  logic                       rstn,
  input  logic                       clear,
  input  logic signed [SAMPLE_W-1:0] seed,
  input  logic        [GAIN_W-1:0]   seed_gain,
  input  logic                       in_valid,
  input  logic signed [SAMPLE_W-1:0] sample,
  input  logic        [GAIN_W-1:0]   gain,
  output logic signed [ACC_W-1:0]    acc,
  output logic                       busy
);

  localparam int PROD_W = SAMPLE_W + GAIN_W;

  logic signed [PROD_W-1:0] word_prod;
  logic signed [PROD_W-1:0] seed_prod;
  logic signed [PROD_W:0]   sum_d;
  logic signed [PROD_W:0]   sum_q;
  logic                     valid_q;
  logic                     clear_q;

  // Gains are unsigned; a zero MSB keeps them positive in the signed multiply.
  assign word_prod = PROD_W'(sample) * PROD_W'(signed'({1'b0, gain}));
  assign seed_prod = PROD_W'(seed) * PROD_W'(signed'({1'b0, seed_gain}));
  assign sum_d     = (in_valid ? (PROD_W+1)'(word_prod) : '0)
                   + (clear    ? (PROD_W+1)'(seed_prod) : '0);
  assign busy      = valid_q;

  // NOTE: every state register here uses <= so all stages sample the same
  // pre-edge values; blocking assignments would collapse the pipeline.
  always_ff @(posedge clk_100MHz or negedge rstn) begin
    if (!rstn) begin
      sum_q   <= '0;
      valid_q <= 1'b0;
      clear_q <= 1'b0;
      acc     <= '0;
    end else begin
      sum_q   <= sum_d;
      valid_q <= in_valid | clear;
      clear_q <= clear;
      if (clear_q) acc <= ACC_W'(sum_q);
      else if (clear) acc <= '0;
      else if (valid_q) acc <= acc + ACC_W'(sum_q);
    end
  end

endmodule

// File: rtl/loop_bank_mixer.sv
// Per-frame stereo mixer of NUM_BANKS loop banks plus a live aux input.
// Optional peak meters are built when LOOP_MIX_PEAK_EN is defined.
module loop_bank_mixer
  import looper_mix_pkg::*;
#(
  parameter int NUM_BANKS = 16,
  parameter int BANK_W    = 4,
  parameter int SAMPLE_W  = 24,
  parameter int WORD_W    = 64,
  parameter int GAIN_W    = 8
) (
  input  logic                        clk_100MHz,
  input  logic                        rstn,
  input  logic                        frame_start,
  input  logic [NUM_BANKS-1:0]        playing,
  input  logic [NUM_BANKS*GAIN_W-1:0] bank_gain,
  input  logic [GAIN_W-1:0]           aux_gain,
  input  logic signed [SAMPLE_W-1:0]  aux_l,
  input  logic signed [SAMPLE_W-1:0]  aux_r,
  input  logic                        data_valid,
  input  logic [BANK_W-1:0]           mem_bank,
  input  logic [WORD_W-1:0]           mem_word,
  input  logic                        mix_data,
  output logic signed [SAMPLE_W-1:0]  mix_l,
  output logic signed [SAMPLE_W-1:0]  mix_r,
  output logic                        mix_valid,
  output logic [1:0]                  clip,
  output logic                        dup_err
`ifdef LOOP_MIX_PEAK_EN
  ,
  output logic [SAMPLE_W-2:0]         peak_l,
  output logic [SAMPLE_W-2:0]         peak_r
`endif
);

  localparam int ACC_W  = SAMPLE_W + GAIN_W + clog2(NUM_BANKS + 1);
  localparam int MASK_W = 1 << BANK_W;

  mix_state_e           state_q, state_d;
  logic                 drain_q, drain_d;
  logic [NUM_BANKS-1:0] playing_q;
  logic [NUM_BANKS-1:0] seen_q, seen_d;
  logic                 started_q;
  logic [MASK_W-1:0]    mask_ext, seen_ext;
  logic                 open_frame, accept, reject, commit, busy_l, busy_r;
  logic [GAIN_W-1:0]    gain_sel;
  logic signed [ACC_W-1:0] acc_l, acc_r;
  sat_t                 sat_l, sat_r;
  logic                 unused_sat;

  // A frame_start in the same cycle wins: the word is judged against the new
  // mask with an empty seen set.
  always_comb begin
    // NOTE: defaults first so every path assigns every variable; otherwise
    // synthesis infers latches.
    mask_ext                = '0;
    seen_ext                = '0;
    mask_ext[NUM_BANKS-1:0] = frame_start ? playing : playing_q;
    seen_ext[NUM_BANKS-1:0] = frame_start ? '0 : seen_q;
    open_frame = frame_start || (state_q == ACCUM);
    accept     = data_valid && open_frame && mask_ext[mem_bank] && !seen_ext[mem_bank];
    reject     = data_valid && !accept && (open_frame || started_q);
    gain_sel   = '0;
    seen_d     = seen_ext[NUM_BANKS-1:0];
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (mem_bank == BANK_W'(k)) gain_sel = bank_gain[k*GAIN_W +: GAIN_W];
      if (accept && mem_bank == BANK_W'(k)) seen_d[k] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = 1'b0;
    if (frame_start) begin
      state_d = ACCUM;
    end else begin
      case (state_q)
        ACCUM:   if (mix_data) state_d = DRAIN;
        DRAIN: begin
          drain_d = 1'b1;
          if (drain_q && !busy_l && !busy_r) state_d = COMMIT;
        end
        COMMIT:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign commit = (state_q == COMMIT) && !frame_start;

  always_ff @(posedge clk_100MHz or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      drain_q   <= 1'b0;
      playing_q <= '0;
      seen_q    <= '0;
      started_q <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      seen_q  <= seen_d;
      if (frame_start) begin
        playing_q <= playing;
        started_q <= 1'b1;
      end
    end
  end

  loop_mix_mac #(.SAMPLE_W(SAMPLE_W), .GAIN_W(GAIN_W), .ACC_W(ACC_W)) u_mac_l (
    .clk_100MHz(clk_100MHz), .rstn(rstn), .clear(frame_start),
    .seed(aux_l), .seed_gain(aux_gain), .in_valid(accept),
    .sample(mem_word[2*SAMPLE_W-1:SAMPLE_W]), .gain(gain_sel),
    .acc(acc_l), .busy(busy_l)
  );

  loop_mix_mac #(.SAMPLE_W(SAMPLE_W), .GAIN_W(GAIN_W), .ACC_W(ACC_W)) u_mac_r (
    .clk_100MHz(clk_100MHz), .rstn(rstn), .clear(frame_start),
    .seed(aux_r), .seed_gain(aux_gain), .in_valid(accept),
    .sample(mem_word[SAMPLE_W-1:0]), .gain(gain_sel),
    .acc(acc_r), .busy(busy_r)
  );

  assign sat_l      = sat_shift(ACC_MAX_W'(acc_l), GAIN_W - 1, SAMPLE_W);
  assign sat_r      = sat_shift(ACC_MAX_W'(acc_r), GAIN_W - 1, SAMPLE_W);
  assign unused_sat = ^{sat_l.value[ACC_MAX_W-1:SAMPLE_W], sat_r.value[ACC_MAX_W-1:SAMPLE_W]};

  generate
    if (WORD_W > 2 * SAMPLE_W) begin : g_word_pad
      logic unused_word;
      assign unused_word = ^mem_word[WORD_W-1:2*SAMPLE_W];
    end
  endgenerate

`ifdef LOOP_MIX_PEAK_EN
  // Magnitude on SAMPLE_W-1 bits; the most negative sample reads as full scale.
  function automatic logic [SAMPLE_W-2:0] mag(input logic signed [SAMPLE_W-1:0] v);
    logic signed [SAMPLE_W-1:0] n;
    n = -v;
    if (!v[SAMPLE_W-1]) return v[SAMPLE_W-2:0];
    if (n[SAMPLE_W-1]) return '1;
    return n[SAMPLE_W-2:0];
  endfunction

  logic [SAMPLE_W-2:0] new_l, new_r, decay_l, decay_r;
  assign new_l   = mag(sat_l.value[SAMPLE_W-1:0]);
  assign new_r   = mag(sat_r.value[SAMPLE_W-1:0]);
  assign decay_l = peak_l - (peak_l >> 6);
  assign decay_r = peak_r - (peak_r >> 6);
`endif

  always_ff @(posedge clk_100MHz or negedge rstn) begin
    if (!rstn) begin
      mix_l     <= '0;
      mix_r     <= '0;
      mix_valid <= 1'b0;
      clip      <= '0;
      dup_err   <= 1'b0;
`ifdef LOOP_MIX_PEAK_EN
      peak_l    <= '0;
      peak_r    <= '0;
`endif
    end else begin
      mix_valid <= commit;
      dup_err   <= frame_start ? reject : (dup_err | reject);
      if (commit) begin
        mix_l <= sat_l.value[SAMPLE_W-1:0];
        mix_r <= sat_r.value[SAMPLE_W-1:0];
        clip  <= {sat_l.clip, sat_r.clip};
`ifdef LOOP_MIX_PEAK_EN
        peak_l <= (new_l > decay_l) ? new_l : decay_l;
        peak_r <= (new_r > decay_r) ? new_r : decay_r;
`endif
      end
    end
  end

endmodule

// File: tb/tb_loop_bank_mixer.sv
// Directed self-checking bench for loop_bank_mixer; peak checks compile in
// only when LOOP_MIX_PEAK_EN is defined.
module tb_loop_bank_mixer;
  import looper_mix_pkg::*;

  localparam int NB = 16, BW = 4, SW = 24, WW = 64, GW = 8;

  logic clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  logic                  rstn, frame_start, data_valid, mix_data;
  logic [NB-1:0]         playing;
  logic [NB*GW-1:0]      bank_gain;
  logic [GW-1:0]         aux_gain;
  logic signed [SW-1:0]  aux_l, aux_r;
  logic [BW-1:0]         mem_bank;
  logic [WW-1:0]         mem_word;
  logic signed [SW-1:0]  mix_l, mix_r;
  logic                  mix_valid, dup_err;
  logic [1:0]            clip;
`ifdef LOOP_MIX_PEAK_EN
  logic [SW-2:0]         peak_l, peak_r;
`endif

  int vectors = 0;
  int miscompares = 0;

  loop_bank_mixer #(.NUM_BANKS(NB), .BANK_W(BW), .SAMPLE_W(SW), .WORD_W(WW), .GAIN_W(GW)) dut (
    .clk_100MHz(clk_100MHz), .rstn(rstn), .frame_start(frame_start), .playing(playing),
    .bank_gain(bank_gain), .aux_gain(aux_gain), .aux_l(aux_l), .aux_r(aux_r),
    .data_valid(data_valid), .mem_bank(mem_bank), .mem_word(mem_word), .mix_data(mix_data),
    .mix_l(mix_l), .mix_r(mix_r), .mix_valid(mix_valid), .clip(clip), .dup_err(dup_err)
`ifdef LOOP_MIX_PEAK_EN
    , .peak_l(peak_l), .peak_r(peak_r)
`endif
  );

  task automatic tick();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic set_gain(input int k, input logic [GW-1:0] g);
    bank_gain[k*GW +: GW] = g;
  endtask

  task automatic start_frame(input logic [NB-1:0] mask);
    playing     = mask;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic send_word(input logic [BW-1:0] bank, input logic [SW-1:0] l, input logic [SW-1:0] r);
    data_valid = 1'b1;
    mem_bank   = bank;
    mem_word   = {16'h0000, l, r};
    tick();
    data_valid = 1'b0;
  endtask

  // lat = negedge index (1-based, after the mix_data edge) of the first mix_valid.
  task automatic close_frame(output int lat);
    mix_data = 1'b1;
    tick();
    mix_data = 1'b0;
    lat = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_100MHz);
      if (mix_valid === 1'b1 && lat < 0) lat = k;
    end
    tick();
  endtask

  task automatic count_pulses(output int pulses);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_100MHz);
      if (mix_valid !== 1'b0) pulses++;
    end
    tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0; frame_start = 1'b0; data_valid = 1'b0; mix_data = 1'b0;
    playing = '0; bank_gain = '0; aux_gain = '0; aux_l = '0; aux_r = '0;
    mem_bank = '0; mem_word = '0;
    repeat (3) @(negedge clk_100MHz);
    vectors++;
    if ({mix_l, mix_r, mix_valid, clip, dup_err} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h/%h v=%b clip=%b dup=%b, want all 0", mix_l, mix_r, mix_valid, clip, dup_err);
    end
    tick();
    rstn = 1'b1;
    tick();
    send_word(4'd3, 24'h000001, 24'h000001);
    @(negedge clk_100MHz);
    vectors++;
    if (dup_err !== 1'b0) begin
      miscompares++;
      $display("FAIL word_before_first_frame: dup_err=%b want 0", dup_err);
    end
    tick();
  endtask

  task automatic test_unity();
    int lat;
    set_gain(0, 8'(gain_unity(GW)));
    start_frame(16'h0001);
    send_word(4'd0, 24'h000100, 24'hFFFF00);
    close_frame(lat);
    vectors++;
    if (lat !== 4) begin miscompares++; $display("FAIL unity_latency: got %0d want 4", lat); end
    vectors++;
    if (mix_l !== 24'h000100) begin miscompares++; $display("FAIL unity_l: got %h want 000100", mix_l); end
    vectors++;
    if (mix_r !== 24'hFFFF00) begin miscompares++; $display("FAIL unity_r: got %h want ffff00", mix_r); end
    vectors++;
    if (clip !== 2'b00 || dup_err !== 1'b0) begin
      miscompares++; $display("FAIL unity_flags: clip=%b dup=%b want 00/0", clip, dup_err);
    end
  endtask

  task automatic test_gain_sum();
    int lat;
    bank_gain = '0;
    set_gain(0, 8'h40);
    set_gain(3, 8'h80);
    aux_l = 24'h000010; aux_r = '0; aux_gain = 8'h80;
    start_frame(16'h0009);
    send_word(4'd0, 24'h100000, 24'h000000);
    send_word(4'd3, 24'h100000, 24'h000000);
    close_frame(lat);
    vectors++;
    if (mix_l !== 24'h180010) begin miscompares++; $display("FAIL gain_sum_l: got %h want 180010", mix_l); end
    vectors++;
    if (mix_r !== 24'h000000 || clip !== 2'b00) begin
      miscompares++; $display("FAIL gain_sum_r: got %h clip=%b want 000000/00", mix_r, clip);
    end
    aux_l = '0; aux_gain = '0;
  endtask

  task automatic test_boundary();
    int lat;
    bank_gain = '0;
    set_gain(0, 8'h80);
    start_frame(16'h0001);
    send_word(4'd0, 24'h7FFFFF, 24'h800000);
    close_frame(lat);
    vectors++;
    if (mix_l !== 24'h7FFFFF || mix_r !== 24'h800000 || clip !== 2'b00) begin
      miscompares++; $display("FAIL full_scale_no_clip: got %h/%h clip=%b want 7fffff/800000/00", mix_l, mix_r, clip);
    end
  endtask

  task automatic test_saturation();
    int lat;
    for (int k = 0; k < 4; k++) set_gain(k, 8'h80);
    start_frame(16'h000F);
    for (int k = 0; k < 4; k++) send_word(4'(k), 24'h7FFFFF, 24'h800000);
    close_frame(lat);
    vectors++;
    if (mix_l !== 24'h7FFFFF || mix_r !== 24'h800000) begin
      miscompares++; $display("FAIL saturation_value: got %h/%h want 7fffff/800000", mix_l, mix_r);
    end
    vectors++;
    if (clip !== 2'b11) begin miscompares++; $display("FAIL saturation_clip: got %b want 11", clip); end
    vectors++;
    if (lat !== 4) begin miscompares++; $display("FAIL saturation_latency: got %0d want 4", lat); end
  endtask

  task automatic test_reset_mid_drain();
    int pulses;
    start_frame(16'h0001);
    send_word(4'd0, 24'h000111, 24'h000000);
    send_word(4'd7, 24'h000001, 24'h000000);
    mix_data = 1'b1;
    tick();
    mix_data = 1'b0;
    rstn = 1'b0;
    #1;
    vectors++;
    if ({mix_l, mix_r, mix_valid, clip, dup_err} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_drain_outputs: got %h/%h v=%b clip=%b dup=%b, want all 0", mix_l, mix_r, mix_valid, clip, dup_err);
    end
    vectors++;
    if (dut.state_q !== IDLE) begin miscompares++; $display("FAIL reset_mid_drain_state: got %0d want IDLE", dut.state_q); end
    tick(); tick();
    rstn = 1'b1;
    count_pulses(pulses);
    vectors++;
    if (pulses !== 0) begin miscompares++; $display("FAIL reset_mid_drain_no_commit: got %0d pulses want 0", pulses); end
  endtask

  task automatic test_rejects();
    int lat;
    bank_gain = '0;
    set_gain(2, 8'h80);
    set_gain(5, 8'h80);
    start_frame(16'h0004);
    send_word(4'd2, 24'h000100, 24'h000000);
    send_word(4'd2, 24'h000200, 24'h000000);
    send_word(4'd5, 24'h000400, 24'h000000);
    close_frame(lat);
    vectors++;
    if (mix_l !== 24'h000100) begin miscompares++; $display("FAIL reject_sum: got %h want 000100", mix_l); end
    vectors++;
    if (dup_err !== 1'b1) begin miscompares++; $display("FAIL reject_dup_err: got %b want 1", dup_err); end
    start_frame(16'h0004);
    vectors++;
    if (dup_err !== 1'b0) begin miscompares++; $display("FAIL dup_err_clear: got %b want 0", dup_err); end
  endtask

  task automatic test_simultaneous();
    int lat;
    set_gain(1, 8'h80);
    playing     = 16'h0002;
    frame_start = 1'b1;
    data_valid  = 1'b1;
    mem_bank    = 4'd1;
    mem_word    = {16'h0000, 24'h000300, 24'h000000};
    tick();
    frame_start = 1'b0;
    data_valid  = 1'b0;
    close_frame(lat);
    vectors++;
    if (mix_l !== 24'h000300 || dup_err !== 1'b0) begin
      miscompares++; $display("FAIL start_with_word: got %h dup=%b want 000300/0", mix_l, dup_err);
    end
    vectors++;
    if (lat !== 4) begin miscompares++; $display("FAIL start_with_word_latency: got %0d want 4", lat); end
  endtask

  task automatic test_abort();
    int pulses, lat;
    set_gain(0, 8'h80);
    start_frame(16'h0001);
    send_word(4'd0, 24'h000555, 24'h000000);
    mix_data = 1'b1;
    tick();
    mix_data = 1'b0;
    start_frame(16'h0001);
    count_pulses(pulses);
    vectors++;
    if (pulses !== 0 || mix_l !== 24'h000300) begin
      miscompares++; $display("FAIL abort_in_drain: pulses=%0d mix_l=%h want 0/000300", pulses, mix_l);
    end
    send_word(4'd0, 24'h000777, 24'h000000);
    start_frame(16'h0001);
    count_pulses(pulses);
    vectors++;
    if (pulses !== 0 || mix_l !== 24'h000300) begin
      miscompares++; $display("FAIL abort_in_accum: pulses=%0d mix_l=%h want 0/000300", pulses, mix_l);
    end
    close_frame(lat);
    vectors++;
    if (mix_l !== 24'h000000 || lat !== 4) begin
      miscompares++; $display("FAIL after_abort_frame: mix_l=%h lat=%0d want 000000/4", mix_l, lat);
    end
  endtask

  task automatic test_silence_idle();
    int lat, pulses;
    aux_l = 24'h000123; aux_r = 24'hFFFFFB; aux_gain = 8'h80;
    start_frame(16'h0000);
    close_frame(lat);
    vectors++;
    if (mix_l !== 24'h000123 || mix_r !== 24'hFFFFFB) begin
      miscompares++; $display("FAIL aux_only: got %h/%h want 000123/fffffb", mix_l, mix_r);
    end
    aux_gain = 8'h00;
    start_frame(16'h0000);
    close_frame(lat);
    vectors++;
    if (mix_l !== 24'h000000 || mix_r !== 24'h000000 || lat !== 4) begin
      miscompares++; $display("FAIL silence: got %h/%h lat=%0d want 0/0/4", mix_l, mix_r, lat);
    end
    mix_data = 1'b1;
    tick();
    mix_data = 1'b0;
    count_pulses(pulses);
    vectors++;
    if (pulses !== 0) begin miscompares++; $display("FAIL mix_data_in_idle: got %0d pulses want 0", pulses); end
    send_word(4'd0, 24'h000001, 24'h000001);
    @(negedge clk_100MHz);
    vectors++;
    if (dup_err !== 1'b1) begin miscompares++; $display("FAIL word_in_idle: dup_err=%b want 1", dup_err); end
    tick();
    aux_l = '0; aux_r = '0;
  endtask

`ifdef LOOP_MIX_PEAK_EN
  task automatic test_peak();
    int lat;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    vectors++;
    if (peak_l !== '0 || peak_r !== '0) begin miscompares++; $display("FAIL peak_reset: got %h/%h want 0/0", peak_l, peak_r); end
    set_gain(0, 8'h80);
    start_frame(16'h0001);
    send_word(4'd0, 24'h400000, 24'h000000);
    close_frame(lat);
    vectors++;
    if (peak_l !== 23'h400000 || peak_r !== 23'h0) begin
      miscompares++; $display("FAIL peak_attack: got %h/%h want 400000/0", peak_l, peak_r);
    end
    start_frame(16'h0000);
    close_frame(lat);
    vectors++;
    if (peak_l !== 23'h3F0000) begin miscompares++; $display("FAIL peak_decay: got %h want 3f0000", peak_l); end
  endtask
`endif

  initial begin
    test_reset();
    test_unity();
    test_gain_sum();
    test_boundary();
    test_saturation();
    test_reset_mid_drain();
    test_rejects();
    test_simultaneous();
    test_abort();
    test_silence_idle();
`ifdef LOOP_MIX_PEAK_EN
    test_peak();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
